// File: rtl/reg_file_8x.sv
// 8-entry register file with one-hot write select, two registered bypassed read ports and a RAW scoreboard.
// Optional macro REGFILE_R0_ZERO_EN makes register 0 a hardwired zero that never goes pending.
module reg_file_8x #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             iss_en,
  input  logic [7:0]       iss_sel,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [7:0]       pend,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs [8];
  logic             wr_onehot;
  logic             iss_onehot;
  logic             wr_ok;
  logic             iss_ok;
  logic             sel_bad;
  logic [7:0]       wr_mask;
  logic [7:0]       iss_mask;
  logic [7:0]       pend_next;
  logic [2:0]       rd_addr [2];
  logic [WIDTH-1:0] rd_next [2];
  logic             hazard_next [2];

  assign wr_onehot  = (wr_sel != 8'd0) && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
  assign iss_onehot = (iss_sel != 8'd0) && ((iss_sel & (iss_sel - 8'd1)) == 8'd0);
  assign wr_ok      = wr_en && wr_onehot;
  assign iss_ok     = iss_en && iss_onehot;
  assign sel_bad    = (wr_en && !wr_onehot) || (iss_en && !iss_onehot);

`ifdef REGFILE_R0_ZERO_EN
  // A legal select of register 0 is accepted but has no effect on state.
  assign wr_mask  = wr_ok  ? (wr_sel  & 8'hFE) : 8'h00;
  assign iss_mask = iss_ok ? (iss_sel & 8'hFE) : 8'h00;
`else
  assign wr_mask  = wr_ok  ? wr_sel  : 8'h00;
  assign iss_mask = iss_ok ? iss_sel : 8'h00;
`endif

  // Issue wins over write-back: the newer instruction owns the register.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pend
      assign pend_next[gi] = iss_mask[gi] | (pend[gi] & ~wr_mask[gi]);
    end
  endgenerate

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rd_next[gi]     = wr_mask[rd_addr[gi]] ? wr_data : regs[rd_addr[gi]];
      assign hazard_next[gi] = pend[rd_addr[gi]] & ~wr_mask[rd_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      rd_data_a <= '0;
      rd_data_b <= '0;
      hazard_a  <= 1'b0;
      hazard_b  <= 1'b0;
      pend      <= 8'h00;
      sel_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_mask[i]) begin
          regs[i] <= wr_data;
        end
      end
      rd_data_a <= rd_next[0];
      rd_data_b <= rd_next[1];
      hazard_a  <= hazard_next[0];
      hazard_b  <= hazard_next[1];
      pend      <= pend_next;
      sel_err   <= sel_err | sel_bad;
    end
  end

endmodule

// File: tb/tb_reg_file_8x.sv
// Self-checking bench for reg_file_8x: directed cases then randomized traffic against an array-based model.
// Honours REGFILE_R0_ZERO_EN when the design is built with it.
module tb_reg_file_8x;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             iss_en;
  logic [7:0]       iss_sel;
  logic             hazard_a;
  logic             hazard_b;
  logic [7:0]       pend;
  logic             sel_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] m_regs [8];
  logic [7:0]       m_pend;
  logic             m_err;

  always #5 clk = ~clk;

  reg_file_8x #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .iss_en(iss_en), .iss_sel(iss_sel), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .pend(pend), .sel_err(sel_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sel_index(input logic [7:0] s);
    for (int i = 0; i < 8; i++) begin
      if (s[i]) return i;
    end
    return 0;
  endfunction

  // One clock: drive inputs, predict outputs from the model, step the model, compare after the edge.
  task automatic cycle(input logic r, input logic we, input logic [7:0] ws, input logic [WIDTH-1:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb, input logic ie, input logic [7:0] is);
    logic [2:0]       addr [2];
    logic [WIDTH-1:0] e_rd [2];
    logic             e_hz [2];
    logic             w_hit, i_hit, bad;
    int               wi, ii;
    rst_n = r; wr_en = we; wr_sel = ws; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; iss_en = ie; iss_sel = is;
    addr[0] = ra; addr[1] = rb;
    wi    = sel_index(ws);
    ii    = sel_index(is);
    bad   = (we && $countones(ws) != 1) || (ie && $countones(is) != 1);
    w_hit = we && $countones(ws) == 1;
    i_hit = ie && $countones(is) == 1;
`ifdef REGFILE_R0_ZERO_EN
    if (wi == 0) w_hit = 1'b0;
    if (ii == 0) i_hit = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      e_rd[p] = (w_hit && wi == int'(addr[p])) ? wd : m_regs[addr[p]];
      e_hz[p] = m_pend[addr[p]] && !(w_hit && wi == int'(addr[p]));
`ifdef REGFILE_R0_ZERO_EN
      if (addr[p] == 3'd0) begin
        e_rd[p] = '0;
        e_hz[p] = 1'b0;
      end
`endif
    end
    if (!r) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pend = 8'h00;
      m_err  = 1'b0;
      e_rd[0] = '0; e_rd[1] = '0;
      e_hz[0] = 1'b0; e_hz[1] = 1'b0;
    end else begin
      if (w_hit) begin
        m_regs[wi] = wd;
        m_pend[wi] = 1'b0;
      end
      if (i_hit) m_pend[ii] = 1'b1;
      m_err = m_err | bad;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("rd_data_a", rd_data_a, e_rd[0]);
    check("rd_data_b", rd_data_b, e_rd[1]);
    check("hazard_a", hazard_a, e_hz[0]);
    check("hazard_b", hazard_b, e_hz[1]);
    check("pend", pend, m_pend);
    check("sel_err", sel_err, m_err);
    $display("cyc=%0d rst_n=%b wr=%b/%h/%h rd=%0d,%0d iss=%b/%h -> a=%h b=%h hz=%b%b pend=%h err=%b",
             cyc, r, we, ws, wd, ra, rb, ie, is, rd_data_a, rd_data_b, hazard_a, hazard_b, pend, sel_err);
  endtask

  initial begin
    logic [7:0]       ws, is;
    logic             we, ie, r;
    logic [WIDTH-1:0] wd;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pend = 8'h00;
    m_err  = 1'b0;

    // Reset held two cycles while a write is attempted
    cycle(1'b0, 1'b1, 8'h04, 16'hBEEF, 3'd2, 3'd2, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h04, 16'hBEEF, 3'd2, 3'd2, 1'b0, 8'h00);
    check("rst_pend", pend, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd2, 3'd2, 1'b0, 8'h00);
    check("rst_reg2", rd_data_a, 16'h0000);
    check("rst_err", sel_err, 1'b0);

    // Write then read latency
    cycle(1'b1, 1'b1, 8'h08, 16'h1234, 3'd0, 3'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd3, 3'd0, 1'b0, 8'h00);
    check("wr_rd_lat", rd_data_a, 16'h1234);

    // Same-cycle bypass on port B
    cycle(1'b1, 1'b1, 8'h20, 16'hA5A5, 3'd0, 3'd5, 1'b0, 8'h00);
    check("bypass_b", rd_data_b, 16'hA5A5);

    // Scoreboard set, hazard, clear with bypass
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b1, 8'h02);
    check("sb_pend_set", pend, 8'h02);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd1, 3'd0, 1'b0, 8'h00);
    check("sb_hazard", hazard_a, 1'b1);
    cycle(1'b1, 1'b1, 8'h02, 16'h7777, 3'd1, 3'd1, 1'b0, 8'h00);
    check("sb_pend_clr", pend, 8'h00);
    check("sb_hz_clr", hazard_a, 1'b0);
    check("sb_rd_new", rd_data_a, 16'h7777);

    // Simultaneous issue and write-back to register 6
    cycle(1'b1, 1'b1, 8'h40, 16'h0F0F, 3'd0, 3'd0, 1'b1, 8'h40);
    check("sim_pend6", pend[6], 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd6, 3'd6, 1'b0, 8'h00);
    check("sim_reg6", rd_data_a, 16'h0F0F);
    check("sim_hz6", hazard_b, 1'b1);
    cycle(1'b1, 1'b1, 8'h40, 16'h0000, 3'd0, 3'd0, 1'b0, 8'h00);

    // Illegal select: nothing stored, error sticks
    cycle(1'b1, 1'b1, 8'h05, 16'hDEAD, 3'd0, 3'd2, 1'b0, 8'h00);
    check("ill_err", sel_err, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd2, 1'b0, 8'h00);
    check("ill_reg2", rd_data_b, 16'h0000);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 8'h00);
    check("ill_sticky", sel_err, 1'b1);

    // Register 0 write then read
    cycle(1'b1, 1'b1, 8'h01, 16'hFFFF, 3'd1, 3'd1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 8'h00);
`ifdef REGFILE_R0_ZERO_EN
    check("r0_read", rd_data_a, 16'h0000);
`else
    check("r0_read", rd_data_a, 16'hFFFF);
`endif

    // Randomized traffic from a clean state
    cycle(1'b0, 1'b0, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0, 8'h00);
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 59) != 0);
      we = ($urandom_range(0, 2) != 0);
      ie = ($urandom_range(0, 2) == 0);
      ws = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      is = ($urandom_range(0, 29) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      if (ie && we && is == ws) is = {is[6:0], is[7]};
      wd = WIDTH'($urandom);
      cycle(r, we, ws, wd, 3'($urandom), 3'($urandom), ie, is);
    end

    cycle(1'b0, 1'b1, 8'h10, 16'h5555, 3'd4, 3'd4, 1'b1, 8'h10);
    check("final_rst_pend", pend, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
